// File: rtl/mc_ctrl_hs_pkg.sv
// rtl/mc_ctrl_hs_pkg.sv - ctrl_pkg: states, RV32I field constants and datapath select encodings
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST_IDLE, S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_EX_BR, S_EX_JAL,
        S_EX_JALR, S_WB_LINK, S_WB_LUI, S_WB_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_SLT  = 4'd4, ALU_SLTU = 4'd5, ALU_XOR = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL  = 4'd8, ALU_SRA = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
    } imm_src_t;

    typedef enum logic [1:0] {
        SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10
    } srca_t;

    typedef enum logic [1:0] {
        SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
    } srcb_t;

    typedef enum logic [1:0] {
        RES_ALUREG = 2'b00, RES_ALU = 2'b01, RES_MDR = 2'b10, RES_IMM = 2'b11
    } res_src_t;

    // 010/011 are not branches; they report not-taken and the FSM traps on them.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic lt, input logic ltu);
        case (f3)
            F3_BEQ:  return zero;
            F3_BNE:  return !zero;
            F3_BLT:  return lt;
            F3_BGE:  return !lt;
            F3_BLTU: return ltu;
            F3_BGEU: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_hs_if.sv
// rtl/mc_ctrl_hs_if.sv - memory request ready/valid handshake between controller and memory
interface mc_ctrl_hs_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/mc_ctrl_hs_alu_dec.sv
// rtl/mc_ctrl_hs_alu_dec.sv - ctrl_alu_dec: {op class, func3, func7} to alu_op plus illegal flag
module ctrl_alu_dec
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic               i_is_imm,
    input  logic [2:0]         i_func3,
    input  logic [6:0]         i_func7,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_illegal
);

    alu_op_t w_op;
    logic    w_base;
    logic    w_alt;

    assign w_base   = (i_func7 == F7_BASE);
    assign w_alt    = (i_func7 == F7_ALT);
    assign o_alu_op = ALUOP_W'(w_op);

    // For I-type only the shifts carry a real func7; elsewhere those bits are immediate.
    always_comb begin
        w_op      = ALU_ADD;
        o_illegal = 1'b0;
        case (i_func3)
            F3_ADD_SUB: begin
                w_op      = (!i_is_imm && w_alt) ? ALU_SUB : ALU_ADD;
                o_illegal = !i_is_imm && !w_base && !w_alt;
            end
            F3_SLL: begin
                w_op      = ALU_SLL;
                o_illegal = !w_base;
            end
            F3_SLT: begin
                w_op      = ALU_SLT;
                o_illegal = !i_is_imm && !w_base;
            end
            F3_SLTU: begin
                w_op      = ALU_SLTU;
                o_illegal = !i_is_imm && !w_base;
            end
            F3_XOR: begin
                w_op      = ALU_XOR;
                o_illegal = !i_is_imm && !w_base;
            end
            F3_SR: begin
                w_op      = w_alt ? ALU_SRA : ALU_SRL;
                o_illegal = !w_base && !w_alt;
            end
            F3_OR: begin
                w_op      = ALU_OR;
                o_illegal = !i_is_imm && !w_base;
            end
            default: begin
                w_op      = ALU_AND;
                o_illegal = !i_is_imm && !w_base;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// rtl/mc_ctrl_hs.sv - multi-cycle RV32I control FSM with ready/valid memory handshake
// Optional memory watchdog: CTRL_TIMEOUT_EN
module mc_ctrl_hs
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_ctrl_hs_if.master       mem,
    input  logic [6:0]         op,
    input  logic [2:0]         func3,
    input  logic [6:0]         func7,
    input  logic               zero,
    input  logic               lt,
    input  logic               ltu,
    output logic               pc_en,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         alusrc_a,
    output logic [1:0]         alusrc_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         result_src,
    output logic [2:0]         imm_src,
    output logic               trap,
    output logic               bus_err
);

    if (ALUOP_W < 4) begin : g_bad_aluop_w
        $error("ALUOP_W must be at least 4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be within 1..65535");
    end

    state_t             r_state;
    state_t             w_next;
    logic [ALUOP_W-1:0] w_dec_alu_op;
    logic               w_dec_illegal;
    logic               w_timeout;

    ctrl_alu_dec #(.ALUOP_W(ALUOP_W)) u_alu_dec (
        .i_is_imm  (op == OP_IMM),
        .i_func3   (func3),
        .i_func7   (func7),
        .o_alu_op  (w_dec_alu_op),
        .o_illegal (w_dec_illegal)
    );

`ifdef CTRL_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        w_waiting;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // A late mem_ready in the limit cycle still completes normally.
    assign w_timeout = w_waiting && !mem.mem_ready && (r_wait_cnt == 16'(TIMEOUT));

    // Leaving a wait state always passes through mem_ready or TRAP, so the clear-on-exit
    // below also gives a clear count on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_waiting && !mem.mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign bus_err = w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                if (w_timeout)          w_next = S_TRAP;
                else if (mem.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_R:              w_next = S_EX_R;
                    OP_IMM:            w_next = S_EX_I;
                    OP_LOAD, OP_STORE: w_next = S_EX_ADDR;
                    OP_BRANCH:         w_next = S_EX_BR;
                    OP_JAL:            w_next = S_EX_JAL;
                    OP_JALR:           w_next = S_EX_JALR;
                    OP_LUI:            w_next = S_WB_LUI;
                    OP_AUIPC:          w_next = S_WB_AUIPC;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_EX_R, S_EX_I: w_next = w_dec_illegal ? S_TRAP : S_WB_ALU;
            S_EX_ADDR: begin
                if (func3 != F3_LW)      w_next = S_TRAP;
                else if (op == OP_STORE) w_next = S_MEM_WR;
                else                     w_next = S_MEM_RD;
            end
            S_MEM_RD: begin
                if (w_timeout)          w_next = S_TRAP;
                else if (mem.mem_ready) w_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (w_timeout)          w_next = S_TRAP;
                else if (mem.mem_ready) w_next = S_FETCH;
            end
            S_WB_ALU, S_WB_MEM, S_WB_LINK, S_WB_LUI, S_WB_AUIPC: w_next = S_FETCH;
            S_EX_BR: w_next = (func3 == 3'b010 || func3 == 3'b011) ? S_TRAP : S_FETCH;
            S_EX_JAL, S_EX_JALR: w_next = S_WB_LINK;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    always_comb begin
        pc_en         = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        mem.adr_src   = 1'b0;
        alusrc_a      = SRCA_PC;
        alusrc_b      = SRCB_RS2;
        alu_op        = ALUOP_W'(ALU_ADD);
        result_src    = RES_ALUREG;
        imm_src       = IMM_I;
        trap          = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alusrc_b    = SRCB_FOUR;
                result_src  = RES_ALU;
                pc_en       = mem.mem_ready;
                ir_write    = mem.mem_ready;
            end
            S_DECODE: begin
                alusrc_a = SRCA_OLDPC;
                alusrc_b = SRCB_IMM;
                imm_src  = IMM_B;
            end
            S_EX_R: begin
                alusrc_a = SRCA_RS1;
                alu_op   = w_dec_alu_op;
            end
            S_EX_I: begin
                alusrc_a = SRCA_RS1;
                alusrc_b = SRCB_IMM;
                alu_op   = w_dec_alu_op;
            end
            S_EX_ADDR: begin
                alusrc_a = SRCA_RS1;
                alusrc_b = SRCB_IMM;
                imm_src  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_RD: begin
                mem.mem_req = 1'b1;
                mem.adr_src = 1'b1;
            end
            S_MEM_WR: begin
                mem.mem_req   = 1'b1;
                mem.mem_write = 1'b1;
                mem.adr_src   = 1'b1;
            end
            S_WB_ALU: reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write  = 1'b1;
                result_src = RES_MDR;
            end
            S_EX_BR: begin
                alusrc_a = SRCA_RS1;
                alu_op   = ALUOP_W'(ALU_SUB);
                pc_en    = branch_taken(func3, zero, lt, ltu);
            end
            S_EX_JAL: begin
                alusrc_a   = SRCA_OLDPC;
                alusrc_b   = SRCB_IMM;
                imm_src    = IMM_J;
                result_src = RES_ALU;
                pc_en      = 1'b1;
            end
            S_EX_JALR: begin
                alusrc_a   = SRCA_RS1;
                alusrc_b   = SRCB_IMM;
                result_src = RES_ALU;
                pc_en      = 1'b1;
            end
            S_WB_LINK: begin
                alusrc_a   = SRCA_OLDPC;
                alusrc_b   = SRCB_FOUR;
                result_src = RES_ALU;
                reg_write  = 1'b1;
            end
            S_WB_LUI: begin
                result_src = RES_IMM;
                imm_src    = IMM_U;
                reg_write  = 1'b1;
            end
            S_WB_AUIPC: begin
                alusrc_a   = SRCA_OLDPC;
                alusrc_b   = SRCB_IMM;
                imm_src    = IMM_U;
                result_src = RES_ALU;
                reg_write  = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// tb/tb_mc_ctrl_hs.sv - directed self-checking bench for mc_ctrl_hs
module tb_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero, lt, ltu;
    logic       pc_en, ir_write, reg_write, trap, bus_err;
    logic [1:0] alusrc_a, alusrc_b, result_src;
    logic [3:0] alu_op;
    logic [2:0] imm_src;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mc_ctrl_hs_if m ();

    mc_ctrl_hs #(.ALUOP_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem(m), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .lt(lt), .ltu(ltu), .pc_en(pc_en), .ir_write(ir_write),
        .reg_write(reg_write), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
        .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
        .trap(trap), .bus_err(bus_err)
    );

    // {pc_en, ir_write, reg_write, mem_req, mem_write, adr_src, A, B, alu_op, result_src, imm_src, trap, bus_err}
    logic [20:0] obs;
    assign obs = {pc_en, ir_write, reg_write, m.mem_req, m.mem_write, m.adr_src,
                  alusrc_a, alusrc_b, alu_op, result_src, imm_src, trap, bus_err};

    function automatic logic [20:0] v(input logic pc, ir, rw, mr, mw, as,
                                      input logic [1:0] a, b, input logic [3:0] ao,
                                      input logic [1:0] rs, input logic [2:0] is,
                                      input logic tr, be);
        return {pc, ir, rw, mr, mw, as, a, b, ao, rs, is, tr, be};
    endfunction

    logic [20:0] V_IDLE, V_FETCH, V_FSTALL, V_DEC, V_WBALU, V_MRD, V_MWR, V_WBMEM;
    logic [20:0] V_LDADDR, V_STADDR, V_JAL, V_JALR, V_LINK, V_LUI, V_AUIPC, V_TRAP;

    task automatic chk(input string tag, input logic [20:0] e);
        #1;
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op = o; func3 = f3; func7 = f7;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m.mem_ready = 1'b1;
        nx();
        rst_n = 1'b1;
    endtask

    initial begin
        V_IDLE   = '0;
        V_FETCH  = v(1,1,0,1,0,0, 2'd0,2'd2,4'd0, 2'd1,3'd0, 0,0);
        V_FSTALL = v(0,0,0,1,0,0, 2'd0,2'd2,4'd0, 2'd1,3'd0, 0,0);
        V_DEC    = v(0,0,0,0,0,0, 2'd1,2'd1,4'd0, 2'd0,3'd2, 0,0);
        V_WBALU  = v(0,0,1,0,0,0, 2'd0,2'd0,4'd0, 2'd0,3'd0, 0,0);
        V_LDADDR = v(0,0,0,0,0,0, 2'd2,2'd1,4'd0, 2'd0,3'd0, 0,0);
        V_STADDR = v(0,0,0,0,0,0, 2'd2,2'd1,4'd0, 2'd0,3'd1, 0,0);
        V_MRD    = v(0,0,0,1,0,1, 2'd0,2'd0,4'd0, 2'd0,3'd0, 0,0);
        V_MWR    = v(0,0,0,1,1,1, 2'd0,2'd0,4'd0, 2'd0,3'd0, 0,0);
        V_WBMEM  = v(0,0,1,0,0,0, 2'd0,2'd0,4'd0, 2'd2,3'd0, 0,0);
        V_JAL    = v(1,0,0,0,0,0, 2'd1,2'd1,4'd0, 2'd1,3'd3, 0,0);
        V_JALR   = v(1,0,0,0,0,0, 2'd2,2'd1,4'd0, 2'd1,3'd0, 0,0);
        V_LINK   = v(0,0,1,0,0,0, 2'd1,2'd2,4'd0, 2'd1,3'd0, 0,0);
        V_LUI    = v(0,0,1,0,0,0, 2'd0,2'd0,4'd0, 2'd3,3'd4, 0,0);
        V_AUIPC  = v(0,0,1,0,0,0, 2'd1,2'd1,4'd0, 2'd1,3'd4, 0,0);
        V_TRAP   = v(0,0,0,0,0,0, 2'd0,2'd0,4'd0, 2'd0,3'd0, 1,0);

        // add x3,x1,x2 with zero-wait memory
        rst_n = 1'b0; m.mem_ready = 1'b1; zero = 0; lt = 0; ltu = 0;
        set_ir(7'b0110011, 3'b000, 7'b0000000);
        chk("rst_low", V_IDLE); nx();
        rst_n = 1'b1;
        chk("rst_idle", V_IDLE); nx();
        chk("add_fetch", V_FETCH); nx();
        chk("add_decode", V_DEC); nx();
        chk("add_exr", v(0,0,0,0,0,0, 2'd2,2'd0,4'd0, 2'd0,3'd0, 0,0)); nx();
        chk("add_wb", V_WBALU); nx();

        // lw with three wait cycles in MEM_RD
        set_ir(7'b0000011, 3'b010, 7'b0000000);
        chk("lw_fetch", V_FETCH); nx();
        chk("lw_decode", V_DEC); nx();
        chk("lw_addr", V_LDADDR); nx();
        m.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait", V_MRD); nx();
        end
        m.mem_ready = 1'b1;
        chk("lw_ready", V_MRD); nx();
        chk("lw_wbmem", V_WBMEM); nx();

        // sw with one wait cycle
        set_ir(7'b0100011, 3'b010, 7'b0000000);
        chk("sw_fetch", V_FETCH); nx();
        chk("sw_decode", V_DEC); nx();
        chk("sw_addr", V_STADDR); nx();
        m.mem_ready = 1'b0;
        chk("sw_wait", V_MWR); nx();
        m.mem_ready = 1'b1;
        chk("sw_ready", V_MWR); nx();

        // branches: bltu/bgeu with ltu=1, bne with zero=0
        set_ir(7'b1100011, 3'b110, 7'b0000000); ltu = 1'b1;
        chk("bltu_fetch", V_FETCH); nx();
        chk("bltu_decode", V_DEC); nx();
        chk("bltu_exbr", v(1,0,0,0,0,0, 2'd2,2'd0,4'd1, 2'd0,3'd0, 0,0)); nx();
        set_ir(7'b1100011, 3'b111, 7'b0000000);
        chk("bgeu_fetch", V_FETCH); nx();
        chk("bgeu_decode", V_DEC); nx();
        chk("bgeu_exbr", v(0,0,0,0,0,0, 2'd2,2'd0,4'd1, 2'd0,3'd0, 0,0)); nx();
        set_ir(7'b1100011, 3'b001, 7'b0000000); ltu = 1'b0; zero = 1'b0;
        chk("bne_fetch", V_FETCH); nx();
        chk("bne_decode", V_DEC); nx();
        chk("bne_exbr", v(1,0,0,0,0,0, 2'd2,2'd0,4'd1, 2'd0,3'd0, 0,0)); nx();

        // sra, srai, andi (func7 bits are immediate for andi)
        set_ir(7'b0110011, 3'b101, 7'b0100000);
        chk("sra_fetch", V_FETCH); nx();
        chk("sra_decode", V_DEC); nx();
        chk("sra_exr", v(0,0,0,0,0,0, 2'd2,2'd0,4'd9, 2'd0,3'd0, 0,0)); nx();
        chk("sra_wb", V_WBALU); nx();
        set_ir(7'b0010011, 3'b101, 7'b0100000);
        chk("srai_fetch", V_FETCH); nx();
        chk("srai_decode", V_DEC); nx();
        chk("srai_exi", v(0,0,0,0,0,0, 2'd2,2'd1,4'd9, 2'd0,3'd0, 0,0)); nx();
        chk("srai_wb", V_WBALU); nx();
        set_ir(7'b0010011, 3'b111, 7'b1010101);
        chk("andi_fetch", V_FETCH); nx();
        chk("andi_decode", V_DEC); nx();
        chk("andi_exi", v(0,0,0,0,0,0, 2'd2,2'd1,4'd2, 2'd0,3'd0, 0,0)); nx();
        chk("andi_wb", V_WBALU); nx();

        // jal, jalr, lui, auipc
        set_ir(7'b1101111, 3'b000, 7'b0000000);
        chk("jal_fetch", V_FETCH); nx();
        chk("jal_decode", V_DEC); nx();
        chk("jal_ex", V_JAL); nx();
        chk("jal_link", V_LINK); nx();
        set_ir(7'b1100111, 3'b000, 7'b0000000);
        chk("jalr_fetch", V_FETCH); nx();
        chk("jalr_decode", V_DEC); nx();
        chk("jalr_ex", V_JALR); nx();
        chk("jalr_link", V_LINK); nx();
        set_ir(7'b0110111, 3'b000, 7'b0000000);
        chk("lui_fetch", V_FETCH); nx();
        chk("lui_decode", V_DEC); nx();
        chk("lui_wb", V_LUI); nx();
        set_ir(7'b0010111, 3'b000, 7'b0000000);
        chk("auipc_fetch", V_FETCH); nx();
        chk("auipc_decode", V_DEC); nx();
        chk("auipc_wb", V_AUIPC); nx();

        // stalled fetch
        set_ir(7'b0110011, 3'b000, 7'b0000000);
        m.mem_ready = 1'b0;
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("to_stall", V_FSTALL); nx();
        end
        chk("to_buserr", V_FSTALL | 21'd1); nx();
        chk("to_trap", V_TRAP); nx();
        do_reset();
        chk("to_idle", V_IDLE); nx();
        m.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_stall", V_FSTALL); nx();
        end
        m.mem_ready = 1'b1;
        chk("late_ready", V_FETCH); nx();
`else
        for (int i = 0; i < 8; i++) begin
            chk("long_stall", V_FSTALL); nx();
        end
        m.mem_ready = 1'b1;
        chk("stall_ready", V_FETCH); nx();
`endif
        chk("stall_decode", V_DEC); nx();
        chk("stall_exr", v(0,0,0,0,0,0, 2'd2,2'd0,4'd0, 2'd0,3'd0, 0,0)); nx();
        chk("stall_wb", V_WBALU); nx();

        // func7=0100000 with func3=110 is illegal
        set_ir(7'b0110011, 3'b110, 7'b0100000);
        chk("badf7_fetch", V_FETCH); nx();
        chk("badf7_decode", V_DEC); nx();
        nx();
        chk("badf7_trap", V_TRAP); nx();
        chk("badf7_sticky", V_TRAP); nx();

        // reset mid-request drops mem_req immediately
        do_reset();
        chk("rst2_idle", V_IDLE); nx();
        m.mem_ready = 1'b0;
        chk("mid_fetch", V_FSTALL);
        rst_n = 1'b0;
        chk("mid_rst", V_IDLE); nx();
        rst_n = 1'b1; m.mem_ready = 1'b1;
        chk("mid_idle", V_IDLE); nx();

        // illegal opcode 0x7F
        set_ir(7'b1111111, 3'b000, 7'b0000000);
        chk("ill_fetch", V_FETCH); nx();
        chk("ill_decode", V_DEC); nx();
        for (int i = 0; i < 3; i++) begin
            chk("ill_trap", V_TRAP); nx();
        end

        // branch func3=010 traps
        do_reset();
        set_ir(7'b1100011, 3'b010, 7'b0000000);
        chk("brx_idle", V_IDLE); nx();
        chk("brx_fetch", V_FETCH); nx();
        chk("brx_decode", V_DEC); nx();
        nx();
        chk("brx_trap", V_TRAP); nx();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
